// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and counter-width helper for the universal shift register.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a shift count of 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; done flags the saturation value.
module sat_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] MaxVal = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == MaxVal);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (optionally rotating), parallel load,
// with a saturating count of shifts since the last load or clear.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter bit               ROTATE  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              d,
    input  logic                          si_msb,
    input  logic                          si_lsb,
    output logic [WIDTH-1:0]              q,
    output logic                          so_lsb,
    output logic                          so_msb,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          done
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shr_in, shl_in;
    logic             is_shift, is_load;

    assign shr_in = ROTATE ? q_q[0]       : si_msb;
    assign shl_in = ROTATE ? q_q[WIDTH-1] : si_lsb;

    assign is_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
    assign is_load  = en && (mode == MODE_LOAD);

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RST_VAL;
        end else if (en) begin
            case (mode)
                MODE_SHR:  q_d = {shr_in, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], shl_in};
                MODE_LOAD: q_d = d;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // A load restarts the count just like a clear does.
    sat_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr || is_load),
        .inc   (is_shift),
        .cnt   (cnt),
        .done  (done)
    );

    assign q      = q_q;
    assign so_lsb = q_q[0];
    assign so_msb = q_q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, successor to the single-bit d_latch/dff_asyn/dff_syn storage cells.
- WIDTH-bit register with clock enable, synchronous clear, parallel load, shift left/right, and an optional rotate mode.
- A shift counter flags when a full word has been serialised.
- Building block for the serialiser/deserialiser and LED-pattern practice designs.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RST_VAL, {WIDTH{1'b0}}, value taken by q on async reset and on synchronous clear.
- ROTATE, 0, 1 = shift operations recirculate the outgoing bit instead of taking the serial input.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  clock enable for load/shift; no effect on clr
- clr  in  1  synchronous clear
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- d  in  WIDTH  parallel load data
- si_msb  in  1  serial input entering the MSB on shift right
- si_lsb  in  1  serial input entering the LSB on shift left
- q  out  WIDTH  register contents
- so_lsb  out  1  = q[0], combinational from q
- so_msb  out  1  = q[WIDTH-1], combinational from q
- cnt  out  CW  shifts since last load/clear; CW = $clog2(WIDTH+1)
- done  out  1  high when cnt == WIDTH

Behaviour:
- Async reset: rst_n low immediately forces q = RST_VAL, cnt = 0, done = 0, independent of clk. Release is sampled on the next rising edge; the first update is on the first edge with rst_n high.
- Priority at each rising edge: clr > (en & mode) > hold.
- clr = 1: q <= RST_VAL, cnt <= 0, regardless of en and mode.
- en = 0 with clr = 0: q and cnt hold.
- mode 00 (hold): q and cnt unchanged.
- mode 11 (load): q <= d, cnt <= 0.
- mode 01 (shift right):
  - ROTATE = 0: q <= {si_msb, q[WIDTH-1:1]}.
  - ROTATE = 1: q <= {q[0], q[WIDTH-1:1]}.
- mode 10 (shift left):
  - ROTATE = 0: q <= {q[WIDTH-2:0], si_lsb}.
  - ROTATE = 1: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- cnt on a shift: increments by 1 and saturates at WIDTH (no wrap). Further shifts still move data while cnt stays at WIDTH.
- done: combinational decode of cnt == WIDTH, so it is high in the cycle after the WIDTH-th shift edge.
- Latency: q, cnt and done reflect an operation one clock after the sampling edge. so_lsb and so_msb follow q with zero delay.
- Serial out timing: so_lsb presents the bit that leaves on the next shift right; so_msb the one that leaves on the next shift left.
- Direction change mid-word: cnt keeps counting total shifts, not net displacement.
- Reset mid-operation: data and count are lost and the register returns to RST_VAL/0. No partial state survives.
- X on mode with en = 1: the verification model flags an error; RTL behaviour is unspecified.

Decomposition:
- Shared header/package holds the mode constants: MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11. It also holds the CW width function/macro.
- One sub-module, sat_counter: parametrised saturating up-counter with sync clear, enable and async active-low reset, providing cnt/done.
- The data path stays in univ_shift_reg.

Test Plan:
All cases use WIDTH = 8, RST_VAL = 8'h00 unless noted.
1. Async reset: load 8'hA5 then pull rst_n low between clock edges -> q = 8'h00, cnt = 0, done = 0 immediately, without waiting for clk.
2. Load then shift right 8 times, ROTATE = 0, si_msb = 0, d = 8'hB4 -> so_lsb sequence 0,0,1,0,1,1,0,1; q = 8'h00 after the 8th shift; done = 1; a 9th shift keeps cnt = 8.
3. Shift left, ROTATE = 1, load 8'h81 -> after 1 shift q = 8'h03; after 8 shifts q = 8'h81 and done = 1.
4. Enable gating: en = 0, mode = 01 for 5 cycles -> q and cnt unchanged. Then clr = 1 with en = 0 -> q = 8'h00, cnt = 0 next edge.
5. Simultaneous clr = 1, en = 1, mode = 11, d = 8'hFF -> q = RST_VAL. Repeat with RST_VAL = 8'h5A -> q = 8'h5A.
6. Deserialise: shift left, ROTATE = 0, feeding si_lsb = 1,1,0,0,1,0,1,0 -> q = 8'hCA with done = 1 in the cycle after the 8th edge.
